// File: rtl/qpd_demod_pkg.sv
// Shared types, constants and arithmetic helpers for the QPD demodulation chain.
package qpd_demod_pkg;

  localparam int unsigned DEF_SIGNAL_BITS   = 24;
  localparam int unsigned DEF_PHASE_BITS    = 32;
  localparam int unsigned DEF_LUT_ADDR_BITS = 10;
  localparam int unsigned DEF_LUT_BITS      = 18;
  localparam int unsigned DEF_LUT_FRAC_BITS = 16;

  localparam int          REF_ONE = 65536;
  localparam int unsigned LATENCY = 4;

  typedef logic signed [DEF_SIGNAL_BITS-1:0] sample_t;
  typedef logic        [DEF_PHASE_BITS-1:0]  phase_t;
  typedef logic signed [DEF_LUT_BITS-1:0]    ref_t;

  // Round half up: add half an LSB of the result, then arithmetic shift.
  function automatic longint round_shift(input longint x, input int unsigned frac);
    return (x + (longint'(1) <<< (frac - 1))) >>> frac;
  endfunction

  // Clamp to the signed range of a 'bits'-wide word.
  function automatic longint saturate(input longint x, input int unsigned bits);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Reference table entry k of a 2^addr_bits table, scaled to REF_ONE,
  // rounded to nearest; evaluated only at elaboration time.
  function automatic int ref_entry(input int k, input int unsigned addr_bits, input bit use_sin);
    real th;
    real v;
    th = 2.0 * 3.14159265358979323846 * real'(k) / real'(2 ** addr_bits);
    v  = real'(REF_ONE) * (use_sin ? $sin(th) : $cos(th));
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

endpackage

// File: rtl/qpd_sincos_lut.sv
// Cosine/sine reference ROM with one registered read cycle.
// Build option QPD_LOCKIN_QUARTER_LUT_EN: store only a quarter-wave cosine
// and rebuild cos/sin by quadrant mirroring; outputs are identical to the
// full-wave tables.
module qpd_sincos_lut
  import qpd_demod_pkg::*;
#(
  parameter int unsigned LUT_ADDR_BITS = DEF_LUT_ADDR_BITS,
  parameter int unsigned LUT_BITS      = DEF_LUT_BITS
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [LUT_ADDR_BITS-1:0]   addr_i,
  output logic signed [LUT_BITS-1:0] cos_o,
  output logic signed [LUT_BITS-1:0] sin_o
);

  logic signed [LUT_BITS-1:0] cos_c;
  logic signed [LUT_BITS-1:0] sin_c;

`ifdef QPD_LOCKIN_QUARTER_LUT_EN
  localparam int unsigned QUARTER = 2 ** (LUT_ADDR_BITS - 2);

  logic signed [LUT_BITS-1:0] qrom [QUARTER+1];

  for (genvar k = 0; k <= QUARTER; k++) begin : g_qrom
    localparam int COS_V = ref_entry(k, LUT_ADDR_BITS, 1'b0);
    assign qrom[k] = LUT_BITS'(COS_V);
  end

  // Quadrants 1 and 3 read the table backwards (QUARTER - idx); quadrants
  // 1 and 2 negate. Entry QUARTER exists so the mirrored index never wraps.
  function automatic logic signed [LUT_BITS-1:0] quad_cos(input logic [LUT_ADDR_BITS-1:0] a);
    logic [LUT_ADDR_BITS-2:0] idx;
    logic [LUT_ADDR_BITS-2:0] mir;
    idx = {1'b0, a[LUT_ADDR_BITS-3:0]};
    mir = (LUT_ADDR_BITS-1)'(QUARTER) - idx;
    case (a[LUT_ADDR_BITS-1 -: 2])
      2'd0:    return qrom[idx];
      2'd1:    return -qrom[mir];
      2'd2:    return -qrom[idx];
      default: return qrom[mir];
    endcase
  endfunction

  // sin(a) = cos(a - quarter period)
  always_comb begin
    cos_c = quad_cos(addr_i);
    sin_c = quad_cos(addr_i - LUT_ADDR_BITS'(QUARTER));
  end
`else
  localparam int unsigned DEPTH = 2 ** LUT_ADDR_BITS;

  logic signed [LUT_BITS-1:0] cos_rom [DEPTH];
  logic signed [LUT_BITS-1:0] sin_rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int COS_V = ref_entry(k, LUT_ADDR_BITS, 1'b0);
    localparam int SIN_V = ref_entry(k, LUT_ADDR_BITS, 1'b1);
    assign cos_rom[k] = LUT_BITS'(COS_V);
    assign sin_rom[k] = LUT_BITS'(SIN_V);
  end

  // Direct full-wave lookup.
  always_comb begin
    cos_c = cos_rom[addr_i];
    sin_c = sin_rom[addr_i];
  end
`endif

  // Registered table output.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cos_o <= '0;
      sin_o <= '0;
    end else begin
      cos_o <= cos_c;
      sin_o <= sin_c;
    end
  end

endmodule

// File: rtl/qpd_lockin_mixer.sv
// Lock-in mixer: multiplies each QPD difference sample by a cos/sin
// reference from a phase accumulator. 4-cycle latency, 1 sample/cycle.
// Build option QPD_LOCKIN_QUARTER_LUT_EN selects the quarter-wave table
// inside qpd_sincos_lut; results are identical either way.
module qpd_lockin_mixer
  import qpd_demod_pkg::*;
#(
  parameter int unsigned SIGNAL_BITS   = DEF_SIGNAL_BITS,
  parameter int unsigned PHASE_BITS    = DEF_PHASE_BITS,
  parameter int unsigned LUT_ADDR_BITS = DEF_LUT_ADDR_BITS,
  parameter int unsigned LUT_BITS      = DEF_LUT_BITS,
  parameter int unsigned LUT_FRAC_BITS = DEF_LUT_FRAC_BITS
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic signed [SIGNAL_BITS-1:0] signal_i,
  input  logic [PHASE_BITS-1:0]         freq_word_i,
  input  logic [PHASE_BITS-1:0]         phase_offset_i,
  input  logic                          sync_i,
  output logic signed [SIGNAL_BITS-1:0] i_o,
  output logic signed [SIGNAL_BITS-1:0] q_o,
  output logic                          done_o
);

  localparam int unsigned PROD_BITS  = SIGNAL_BITS + LUT_BITS;
  localparam int unsigned ADDR_SHIFT = PHASE_BITS - LUT_ADDR_BITS;

  logic [PHASE_BITS-1:0]         acc;
  logic [PHASE_BITS-1:0]         acc_base;
  logic [LUT_ADDR_BITS-1:0]      lookup_addr;
  logic [LUT_ADDR_BITS-1:0]      s1_addr;
  logic signed [SIGNAL_BITS-1:0] s1_sig;
  logic signed [SIGNAL_BITS-1:0] s2_sig;
  logic signed [LUT_BITS-1:0]    cos_q;
  logic signed [LUT_BITS-1:0]    sin_q;
  logic signed [PROD_BITS-1:0]   prod_i;
  logic signed [PROD_BITS-1:0]   prod_q;
  logic [LATENCY-1:0]            vld;

  // sync_i zeroes the accumulator as seen by a sample in the same cycle.
  always_comb begin
    acc_base    = sync_i ? '0 : acc;
    lookup_addr = LUT_ADDR_BITS'((acc_base + phase_offset_i) >> ADDR_SHIFT);
  end

  // Phase accumulator: advances only on accepted samples, wraps silently.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc <= '0;
    end else if (start_i) begin
      acc <= acc_base + freq_word_i;
    end else if (sync_i) begin
      acc <= '0;
    end
  end

  // S0: capture sample and table address.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_sig  <= '0;
      s1_addr <= '0;
    end else if (start_i) begin
      s1_sig  <= signal_i;
      s1_addr <= lookup_addr;
    end
  end

  qpd_sincos_lut #(
    .LUT_ADDR_BITS (LUT_ADDR_BITS),
    .LUT_BITS      (LUT_BITS)
  ) u_lut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .addr_i  (s1_addr),
    .cos_o   (cos_q),
    .sin_o   (sin_q)
  );

  // S1 sample delay alongside the table read, then S2 signed multiply.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s2_sig <= '0;
      prod_i <= '0;
      prod_q <= '0;
    end else begin
      s2_sig <= s1_sig;
      prod_i <= PROD_BITS'(s2_sig) * PROD_BITS'(cos_q);
      prod_q <= PROD_BITS'(s2_sig) * PROD_BITS'(sin_q);
    end
  end

  // S3: round, saturate, register; outputs hold between valid samples.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      i_o <= '0;
      q_o <= '0;
    end else if (vld[LATENCY-2]) begin
      i_o <= SIGNAL_BITS'(saturate(round_shift(longint'(prod_i), LUT_FRAC_BITS), SIGNAL_BITS));
      q_o <= SIGNAL_BITS'(saturate(round_shift(longint'(prod_q), LUT_FRAC_BITS), SIGNAL_BITS));
    end
  end

  // Valid shift register; reset drops every in-flight sample.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld <= '0;
    end else begin
      vld <= {vld[LATENCY-2:0], start_i};
    end
  end

  assign done_o = vld[LATENCY-1];

endmodule
